// File: rtl/mem_narrow_port_arbiter.sv
// Round-robin arbiter sharing one narrow memory port among NumReq requesters.
// Responses are routed back in issue order through an outstanding-ID FIFO.
module mem_narrow_port_arbiter #(
  parameter int NumReq         = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 4,
  parameter int IdxW           = $clog2(NumReq)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_gnt_o,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq-1:0]               req_we_i,
  input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0]   req_strb_i,
  output logic [NumReq-1:0]               rsp_valid_o,
  output logic [DataWidth-1:0]            rsp_rdata_o,
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic                            mem_we_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  output logic [DataWidth/8-1:0]          mem_strb_o,
  input  logic                            mem_rvalid_i,
  input  logic [DataWidth-1:0]            mem_rdata_i,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int StrbW = DataWidth / 8;
  localparam int CntW  = $clog2(MaxOutstanding + 1);
  localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdxW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [IdxW-1:0] fifo_d [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  int              cand;
  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  logic            lock_viol;
  logic            issue_ok;
  logic            mem_req;
  logic            hs;
  logic            pop;
  logic            empty_err;
  logic [IdxW-1:0] head;

  always_comb begin
    cand      = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    if (lock_q && req_valid_i[lock_idx_q]) begin
      win_valid = 1'b1;
      win_idx   = lock_idx_q;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        cand = (int'(rr_q) + i) % NumReq;
        if (!win_valid && req_valid_i[cand]) begin
          win_valid = 1'b1;
          win_idx   = IdxW'(cand);
        end
      end
    end
  end

  // Issue is gated on the registered count only; a same-cycle pop gives no credit.
  assign lock_viol = lock_q & ~req_valid_i[lock_idx_q];
  assign issue_ok  = cnt_q < CntW'(MaxOutstanding);
  assign mem_req   = win_valid & issue_ok;
  assign hs        = mem_req & mem_gnt_i;
  assign pop       = mem_rvalid_i & (cnt_q != '0);
  assign empty_err = mem_rvalid_i & (cnt_q == '0);
  assign head      = fifo_q[rptr_q];

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | lock_viol | empty_err;
    if (lock_viol) begin
      lock_d = 1'b0;
    end
    if (hs) begin
      fifo_d[wptr_q] = win_idx;
      wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
      rr_d   = IdxW'((int'(win_idx) + 1) % NumReq);
      lock_d = 1'b0;
    end else if (mem_req) begin
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    unique case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Every output is forced low while reset is held, independent of inputs.
  always_comb begin
    req_gnt_o   = '0;
    rsp_valid_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      req_gnt_o[k]   = hs  && (win_idx == IdxW'(k));
      rsp_valid_o[k] = pop && (head == IdxW'(k));
    end
    if (rst_i) begin
      req_gnt_o   = '0;
      rsp_valid_o = '0;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    if (win_valid && !rst_i) begin
      mem_addr_o  = req_addr_i[win_idx*AddrWidth +: AddrWidth];
      mem_we_o    = req_we_i[win_idx];
      mem_wdata_o = req_wdata_i[win_idx*DataWidth +: DataWidth];
      mem_strb_o  = req_strb_i[win_idx*StrbW +: StrbW];
    end
  end

  assign mem_req_o   = mem_req & ~rst_i;
  assign rsp_rdata_o = rst_i ? '0 : mem_rdata_i;
  assign busy_o      = (cnt_q != '0) & ~rst_i;
  assign err_o       = err_q & ~rst_i;

endmodule

// File: tb/tb_mem_narrow_port_arbiter.sv
// Randomized scoreboard bench for mem_narrow_port_arbiter.
// Driver pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_mem_narrow_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_gnt_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N-1:0]    req_we_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N*SW-1:0] req_strb_i;
  logic [N-1:0]    rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            mem_req_o;
  logic            mem_gnt_i;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_we_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [SW-1:0]   mem_strb_o;
  logic            mem_rvalid_i;
  logic [DW-1:0]   mem_rdata_i;
  logic            busy_o;
  logic            err_o;

  always #5 clk = ~clk;

  mem_narrow_port_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_gnt_o(req_gnt_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic [109:0]  iss;
    logic          busy;
    logic [N-1:0]  rsp;
    logic [DW-1:0] rdata;
  } rec_t;

  rec_t        rec_q[$];
  rec_t        mr;
  logic [DW-1:0] pend_q[$];
  int          ord_q[$];
  int          pass_cnt = 0;
  int          tot_cnt  = 0;

  bit          v   [N];
  logic [AW-1:0] pa  [N];
  logic          pwe [N];
  logic [DW-1:0] pwd [N];
  logic [SW-1:0] pst [N];
  int          rr  = 0;
  bit          lk  = 0;
  int          lki = 0;

  task automatic chk(input string nm, input logic [255:0] a,
                     input logic [255:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, a, e);
  endtask

  always @(negedge clk) begin
    if (rec_q.size() > 0) begin
      mr = rec_q.pop_front();
      chk("issue", {mem_req_o, req_gnt_o, mem_addr_o, mem_we_o,
                    mem_wdata_o, mem_strb_o}, mr.iss);
      chk("busy", busy_o, mr.busy);
      chk("rsp_valid", rsp_valid_o, mr.rsp);
      if (mr.rsp != '0) chk("rsp_rdata", rsp_rdata_o, mr.rdata);
      chk("err_clean", err_o, 1'b0);
    end
  end

  task automatic idle_inputs();
    req_valid_i  = '0;
    req_addr_i   = '0;
    req_we_i     = '0;
    req_wdata_i  = '0;
    req_strb_i   = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: round-robin from rr, lock held on refused requests, in-order responses.
  task automatic cyc(input bit allow, input int gprob, input int rprob);
    rec_t         r;
    int           win;
    int           h;
    int           outst;
    bit           any;
    bit           req;
    logic [N-1:0] gv;
    step();
    for (int k = 0; k < N; k++) begin
      if (allow && !v[k] && $urandom_range(0, 2) == 0) begin
        v[k]   = 1'b1;
        pa[k]  = 32'($urandom_range(0, 255)) << 3;
        pwe[k] = 1'($urandom_range(0, 1));
        pwd[k] = {$urandom, $urandom};
        pst[k] = 8'($urandom);
      end
      req_valid_i[k]          = v[k];
      req_addr_i[k*AW +: AW]  = pa[k];
      req_we_i[k]             = pwe[k];
      req_wdata_i[k*DW +: DW] = pwd[k];
      req_strb_i[k*SW +: SW]  = pst[k];
    end
    mem_gnt_i = ($urandom_range(0, 99) < gprob);
    outst = pend_q.size();
    r.rsp   = '0;
    r.rdata = '0;
    if (outst > 0 && $urandom_range(0, 99) < rprob) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend_q.pop_front();
      h            = ord_q.pop_front();
      r.rsp[h]     = 1'b1;
      r.rdata      = mem_rdata_i;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = {$urandom, $urandom};
    end
    any = 1'b0;
    win = 0;
    if (lk && v[lki]) begin
      any = 1'b1;
      win = lki;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!any && v[(rr + i) % N]) begin
          any = 1'b1;
          win = (rr + i) % N;
        end
      end
    end
    req = any && (outst < MO);
    gv  = (req && mem_gnt_i) ? 4'(1 << win) : 4'b0;
    r.iss  = any ? {req, gv, pa[win], pwe[win], pwd[win], pst[win]} : '0;
    r.busy = (outst != 0);
    rec_q.push_back(r);
    if (req && mem_gnt_i) begin
      pend_q.push_back({$urandom, $urandom});
      ord_q.push_back(win);
      v[win] = 1'b0;
      rr     = (win + 1) % N;
      lk     = 1'b0;
    end else if (req) begin
      lk  = 1'b1;
      lki = win;
    end
  endtask

  function automatic bit any_v();
    bit a;
    a = 1'b0;
    for (int k = 0; k < N; k++) a |= v[k];
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b0; pa[k] = '0; pwe[k] = 1'b0; pwd[k] = '0; pst[k] = '0;
    end
    idle_inputs();
    rst          = 1'b1;
    req_valid_i  = '1;
    req_addr_i   = {N{32'h0000_0040}};
    req_we_i     = '1;
    req_wdata_i  = {N{64'hDEAD_BEEF}};
    req_strb_i   = '1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'hDEAD_BEEF;
    #2;
    chk("reset_outputs", {req_gnt_o, rsp_valid_o, rsp_rdata_o, mem_req_o,
        mem_addr_o, mem_we_o, mem_wdata_o, mem_strb_o, busy_o, err_o}, '0);
    step();
    rst = 1'b0;
    idle_inputs();

    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 250; c++) begin
        cyc(1'b1, (p % 2 == 1) ? 40 : 90, (p < 4) ? 60 : 15);
      end
    end
    for (int t = 0; t < 200 && (pend_q.size() > 0 || any_v()); t++) begin
      cyc(1'b0, 100, 100);
    end
    chk("drain_pending", pend_q.size(), 0);
    chk("drain_requests", any_v(), 1'b0);
    @(negedge clk);

    step();
    idle_inputs();
    #1;
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_err", err_o, 1'b0);
    step();
    mem_rvalid_i = 1'b1;
    #1;
    chk("empty_rsp_valid", rsp_valid_o, '0);
    step();
    mem_rvalid_i = 1'b0;
    #1;
    chk("empty_err_set", err_o, 1'b1);
    chk("empty_busy", busy_o, 1'b0);
    step();
    #1;
    chk("err_sticky", err_o, 1'b1);

    step();
    req_valid_i = 4'b0010;
    req_addr_i[1*AW +: AW] = 32'h40;
    mem_gnt_i = 1'b1;
    #1;
    chk("single_gnt", req_gnt_o, 4'b0010);
    chk("single_addr", mem_addr_o, 32'h40);
    step();
    req_valid_i = 4'b1000;
    #1;
    chk("second_gnt", req_gnt_o, 4'b1000);
    chk("busy_inflight", busy_o, 1'b1);
    step();
    req_valid_i = 4'b0100;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {req_gnt_o, rsp_valid_o, rsp_rdata_o, mem_req_o,
        mem_addr_o, mem_we_o, mem_wdata_o, mem_strb_o, busy_o, err_o}, '0);
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_err", err_o, 1'b0);
    step();
    mem_rvalid_i = 1'b1;
    #1;
    chk("late_rsp_valid", rsp_valid_o, '0);
    step();
    mem_rvalid_i = 1'b0;
    #1;
    chk("late_rsp_err", err_o, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mem_narrow_port_arbiter.md
Name: mem_narrow_port_arbiter

Overview:
- Shares one direct narrow memory port of the memory island among NumReq requesters, e.g. accelerator load/store units.
- Round-robin arbitration on the request channel, with a lock held until the memory grants.
- In-order response routing through an outstanding-ID FIFO, with a bounded number of in-flight transactions.
- Sits between the requesters and one mem_narrow_req_i/mem_narrow_rsp_o slot of memory_island_wrap.

Parameters:
- NumReq, 4, number of requesters; must be ≥2.
- AddrWidth, 32, byte address width.
- DataWidth, 64, data width; strobe width is DataWidth/8.
- MaxOutstanding, 4, maximum in-flight transactions; must be ≥1.
- IdxW, $clog2(NumReq), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NumReq  per-requester request.
- req_gnt_o  out  NumReq  per-requester grant.
- req_addr_i  in  NumReq*AddrWidth  packed addresses; requester k occupies slice k.
- req_we_i  in  NumReq  write enable.
- req_wdata_i  in  NumReq*DataWidth  write data.
- req_strb_i  in  NumReq*DataWidth/8  byte strobes.
- rsp_valid_o  out  NumReq  per-requester response valid.
- rsp_rdata_o  out  DataWidth  read data, broadcast to all requesters.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  AddrWidth  memory address.
- mem_we_o  out  1  memory write enable.
- mem_wdata_o  out  DataWidth  memory write data.
- mem_strb_o  out  DataWidth/8  memory byte strobes.
- mem_rvalid_i  in  1  memory response valid (one per granted request, in order, latency ≥1).
- mem_rdata_i  in  DataWidth  memory read data.
- busy_o  out  1  asserted when outstanding count ≠ 0.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i high, asynchronous):
  - rr pointer = 0, lock cleared, FIFO empty, count = 0, err_o = 0.
  - All outputs combinationally 0 while rst_i is high, including mem_req_o, req_gnt_o, rsp_valid_o and busy_o.
  - Reset mid-transaction drops all in-flight IDs. Late mem_rvalid_i after reset release counts as an empty-FIFO error.
- Requester protocol: once req_valid_i[k] is raised, it is held with stable payload until req_gnt_o[k]=1.
- Arbitration is combinational:
  - If unlocked, the winner is the first asserted req_valid_i scanning from the rr pointer upward, with wrap-around.
  - If locked, the winner is the locked index.
- Issue gating: mem_req_o = (any winner) & (count < MaxOutstanding). There is no same-cycle pop credit, so when count == MaxOutstanding, mem_req_o = 0 even if mem_rvalid_i = 1.
- mem_addr_o, mem_we_o, mem_wdata_o and mem_strb_o are muxed from the winner. They are 0 when there is no winner.
- Handshake occurs when mem_req_o & mem_gnt_i:
  - req_gnt_o[winner] = 1 in the same cycle.
  - Winner index is pushed to the FIFO.
  - rr pointer ← (winner+1) mod NumReq.
  - Lock cleared.
- mem_req_o=1 & mem_gnt_i=0: lock ← 1 and locked index ← winner. The winner is held regardless of higher-priority arrivals.
- If the locked requester drops req_valid_i (protocol violation): lock cleared, err_o ← 1.
- Response path:
  - On mem_rvalid_i, pop the FIFO head h and set rsp_valid_o[h] = 1 in the same cycle (zero added latency).
  - rsp_rdata_o = mem_rdata_i, unregistered.
  - Writes also receive a response.
- Count update:
  - push & pop: count unchanged.
  - push only: +1.
  - pop only: −1.
- mem_rvalid_i with an empty FIFO: no rsp_valid_o asserted, count stays 0, err_o ← 1.
- Response order: responses return in issue order. No reordering across requesters.
- Throughput: one issue per cycle when mem_gnt_i is held high and responses keep pace.

Test Plan:
- Single request: req 2 read addr 0x40 with immediate gnt; rvalid 2 cycles later with rdata 0xDEAD_BEEF → req_gnt_o=4'b0100 in the issue cycle, rsp_valid_o=4'b0100 with rdata 0xDEAD_BEEF, busy_o high for exactly 2 cycles.
- Round robin: all 4 requesters held high, gnt always 1 → grant order 0,1,2,3,0,… over 8 cycles, given response latency 1.
- Lock: req 1 asserted with gnt low for 3 cycles, req 0 rises in cycle 1 → winner stays 1 until gnt, then req 0 is granted next.
- Outstanding cap (MaxOutstanding=4): gnt=1, no rvalid for 6 cycles → exactly 4 grants, then mem_req_o=0. The first rvalid re-enables issue the following cycle.
- Response routing: issue order 3,0,3 with rvalid back-to-back → rsp_valid_o = 1000, 0001, 1000.
- Errors and reset: rvalid with an empty FIFO → err_o=1 sticky. Assert rst_i with 2 in flight → all outputs 0 immediately; after release err_o=0 and busy_o=0.
